// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_mux_pkg
//  Description : Shared definitions for the rr_arb_mux arbitrated multiplexer:
//                arbiter state encoding and arbitration-mode constants.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_arb_mux_pkg;

    // IDLE arbitrates every cycle; LOCK keeps the grant until a last beat.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb_mux_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_mux_pick
//  Description : Combinational rotating-priority picker. Returns the first
//                requesting index at or above base (wrapping modulo N), or the
//                lowest requesting index when fixed=1.
//  Ports       : req[N]        request vector
//                base[SELW]    highest-priority index for rotating mode
//                fixed         1 = ignore base, index 0 has top priority
//                gnt_idx[SELW] winning index (0 when no request)
//                any           at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb_mux_pick #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] base,
    input  logic            fixed,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    // One extra bit so base+offset cannot overflow before the modulo fold.
    localparam int            IW  = SELW + 1;
    localparam logic [IW-1:0] C_N = IW'(N);

    logic [SELW-1:0] w_base;
    logic [IW-1:0]   w_idx;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = '0;
        w_base  = fixed ? '0 : base;
        // Walk offsets from lowest priority to highest so the highest-priority
        // requester is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = IW'(w_base) + IW'(i);
            if (w_idx >= C_N) begin
                w_idx = w_idx - C_N;
            end
            if (req[w_idx[SELW-1:0]]) begin
                gnt_idx = w_idx[SELW-1:0];
                any     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_mux
//  Description : N-input, WIDTH-bit arbitrated multiplexer with a registered
//                output stage. Round-robin or fixed-priority arbitration; the
//                grant is held for a whole packet (until a last beat).
//  Ports       : clk, rst               clock, synchronous active-high reset
//                mode                   0 = round-robin, 1 = fixed priority
//                in_valid/in_data/in_last/in_ready   N source channels
//                out_valid/out_data/out_last/out_sel/out_ready  sink channel
//                busy                   1 while a packet holds the grant
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready,
    output logic               busy
);

    import rr_arb_mux_pkg::*;

    state_e           r_state_q,     w_state_d;
    logic [SELW-1:0]  r_rr_ptr_q,    w_rr_ptr_d;
    logic [SELW-1:0]  r_grant_q,     w_grant_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic             r_out_last_q,  w_out_last_d;
    logic [SELW-1:0]  r_out_sel_q,   w_out_sel_d;

    logic [SELW-1:0]  w_pick_idx;
    logic             w_pick_any;
    logic [SELW-1:0]  w_gnt;
    logic             w_have_gnt;
    logic             w_slot_free;
    logic             w_accept;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_gnt_valid;
    logic             w_gnt_last;

    rr_arb_mux_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .base    (r_rr_ptr_q),
        .fixed   (mode == MODE_FIXED),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    // In LOCK the stored grant is used and the picker (and mode) are ignored.
    assign w_gnt       = (r_state_q == ST_LOCK) ? r_grant_q : w_pick_idx;
    assign w_have_gnt  = (r_state_q == ST_LOCK) ? 1'b1      : w_pick_any;
    assign w_slot_free = !r_out_valid_q || out_ready;

    always_comb begin
        w_gnt_data  = '0;
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt == SELW'(k)) begin
                w_gnt_data  = in_data[k*WIDTH +: WIDTH];
                w_gnt_valid = in_valid[k];
                w_gnt_last  = in_last[k];
            end
        end
    end

    // Reset blanks in_ready so no source believes a beat was taken while the
    // output stage is being cleared.
    always_comb begin
        in_ready = '0;
        if (!rst && w_have_gnt && w_slot_free) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    assign w_accept = !rst && w_have_gnt && w_slot_free && w_gnt_valid;

    always_comb begin
        w_state_d     = r_state_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        w_grant_d     = r_grant_q;
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_last_d  = r_out_last_q;
        w_out_sel_d   = r_out_sel_q;
        if (w_accept) begin
            w_out_valid_d = 1'b1;
            w_out_data_d  = w_gnt_data;
            w_out_last_d  = w_gnt_last;
            w_out_sel_d   = w_gnt;
            if (w_gnt_last) begin
                w_state_d  = ST_IDLE;
                w_rr_ptr_d = (w_gnt == SELW'(N - 1)) ? '0 : w_gnt + 1'b1;
            end else begin
                w_state_d = ST_LOCK;
                w_grant_d = w_gnt;
            end
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_rr_ptr_q    <= '0;
            r_grant_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_last_q  <= 1'b0;
            r_out_sel_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_grant_q     <= w_grant_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_last_q  <= w_out_last_d;
            r_out_sel_q   <= w_out_sel_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign out_last  = r_out_last_q;
    assign out_sel   = r_out_sel_q;
    assign busy      = (r_state_q == ST_LOCK);

endmodule
`default_nettype wire
